// File: rtl/bitrev_sched_if.sv
// Handshake bundle for bitrev_sched.
//   req0_*/req1_* : two requesters offering a byte (valid/data in, ready out of the block)
//   out_*         : reversed byte toward the consumer (valid/data/id out, ready in)
//   busy          : block is in a state other than idle
// slave modport is the bitrev_sched side, master modport is the requester/consumer side.
interface bitrev_sched_if;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_id;
   logic       out_ready;
   logic       busy;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
      output req0_ready, req1_ready, out_valid, out_data, out_id, busy
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, out_ready,
      input  req0_ready, req1_ready, out_valid, out_data, out_id, busy
   );
endinterface

// File: rtl/bitrev_sched.sv
// Two-requester round-robin bit reverser.
// A byte accepted from one requester is shifted out LSB-first into a result register over
// eight cycles, then presented as out_data (bit-reversed) with out_id until the consumer
// accepts it. Only one transaction is in flight at a time.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : bitrev_sched_if.slave (request, output and busy signals)
module bitrev_sched (
   input  logic           clk,
   input  logic           rst_n,
   bitrev_sched_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e     state_q, state_d;
   logic [7:0] src_q, src_d;
   logic [7:0] res_q, res_d;
   logic [2:0] cnt_q, cnt_d;
   logic       id_q, id_d;
   logic       last_q, last_d;

   logic grant0, grant1;
   logic acc0, acc1;

   // Round-robin: on contention the requester not granted last wins. Gated by rst_n so
   // nothing looks accepted during a reset cycle.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n && (state_q == StIdle)) begin
         grant0 = bus.req0_valid && (!bus.req1_valid || last_q);
         grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign acc0           = grant0 && bus.req0_valid;
   assign acc1           = grant1 && bus.req1_valid;

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      last_d  = last_q;
      case (state_q)
         StIdle: begin
            if (acc0 || acc1) begin
               src_d   = acc0 ? bus.req0_data : bus.req1_data;
               id_d    = acc1;
               last_d  = acc1;
               res_d   = 8'h00;
               cnt_d   = 3'd0;
               state_d = StShift;
            end
         end
         StShift: begin
            res_d = {res_q[6:0], src_q[0]};
            src_d = src_q >> 1;
            cnt_d = cnt_q + 3'd1;
            // Eighth shift lands here; the counter wrap is harmless because we leave SHIFT.
            if (cnt_q == 3'd7) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         src_q   <= 8'h00;
         res_q   <= 8'h00;
         cnt_q   <= 3'd0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         last_q  <= last_d;
      end
   end

   assign bus.out_valid = rst_n && (state_q == StDone);
   assign bus.out_data  = bus.out_valid ? res_q : 8'h00;
   assign bus.out_id    = id_q;
   assign bus.busy      = rst_n && (state_q != StIdle);

endmodule

// File: tb/tb_bitrev_sched.sv
module tb_bitrev_sched;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_fail;

   bitrev_sched_if bus ();

   bitrev_sched u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state, owned by the monitor.
   bit         m_idle;
   bit         m_last;
   int         m_acc_edge;
   logic [8:0] sb[$];
   bit         hold;
   logic [8:0] held;

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7 - i];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      m_idle = 1'b1;
      m_last = 1'b1;
      m_acc_edge = 0;
      hold = 1'b0;
      held = '0;
   end

   // Monitor: predicts every edge from the inputs sampled mid-cycle.
   always @(negedge clk) begin : monitor
      logic er0, er1, ev;
      logic [8:0] exp;
      er0 = rst_n && m_idle && bus.req0_valid && (!bus.req1_valid || m_last);
      er1 = rst_n && m_idle && bus.req1_valid && (!bus.req0_valid || !m_last);
      ev  = rst_n && !m_idle && (cyc >= m_acc_edge + 8);
      check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, er0});
      check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, er1});
      check("busy", {31'd0, bus.busy}, {31'd0, rst_n && !m_idle});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
      if (!bus.out_valid) check("out_data_zero", {24'd0, bus.out_data}, 32'd0);
      if (hold && ev) check("done_stable", {23'd0, bus.out_id, bus.out_data}, {23'd0, held});
      if (!rst_n) begin
         m_idle = 1'b1;
         m_last = 1'b1;
         sb.delete();
         hold = 1'b0;
      end else begin
         if (ev && bus.out_ready) begin
            check("scoreboard_count", sb.size(), 1);
            if (sb.size() > 0) begin
               exp = sb.pop_front();
               check("out_data", {24'd0, bus.out_data}, {24'd0, exp[7:0]});
               check("out_id", {31'd0, bus.out_id}, {31'd0, exp[8]});
            end
            m_idle = 1'b1;
            hold = 1'b0;
         end else if (ev) begin
            hold = 1'b1;
            held = {bus.out_id, bus.out_data};
         end else begin
            hold = 1'b0;
         end
         if (er0) begin
            sb.push_back({1'b0, rev8(bus.req0_data)});
            m_last = 1'b0;
            m_idle = 1'b0;
            m_acc_edge = cyc + 1;
         end else if (er1) begin
            sb.push_back({1'b1, rev8(bus.req1_data)});
            m_last = 1'b1;
            m_idle = 1'b0;
            m_acc_edge = cyc + 1;
         end
      end
   end

   // Offer one byte and hold it until accepted; returns mid-cycles waited.
   task automatic send(input bit which, input logic [7:0] d, output int waits);
      bit got;
      got = 1'b0;
      waits = 0;
      if (which) begin
         bus.req1_valid = 1'b1;
         bus.req1_data  = d;
      end else begin
         bus.req0_valid = 1'b1;
         bus.req0_data  = d;
      end
      while (!got && waits < 40) begin
         @(negedge clk);
         waits++;
         got = which ? (bus.req1_valid && bus.req1_ready) : (bus.req0_valid && bus.req0_ready);
      end
      if (!got) check("send_timeout", waits, 0);
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((bus.busy || bus.out_valid) && n < 60);
      if (bus.busy) check("idle_timeout", n, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int w;
      int n;
      int prev;
      logic [7:0] dirs[4];
      n_checks = 0;
      n_fail = 0;
      rst_n = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req0_data  = 8'h00;
      bus.req1_valid = 1'b0;
      bus.req1_data  = 8'h00;
      bus.out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single transactions from each requester, including all-zero and all-one bytes.
      send(1'b0, 8'h01, w);
      check("accept_after_reset", w, 1);
      wait_idle();
      dirs[0] = 8'hB4; dirs[1] = 8'h00; dirs[2] = 8'hFF; dirs[3] = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         send(1'b1, dirs[i], w);
         wait_idle();
      end

      // Contention after reset: both held valid, four grants.
      do_reset(1);
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'h0F;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'h3C;
      n = 0;
      for (int k = 0; k < 80 && n < 4; k++) begin
         @(negedge clk);
         if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) n++;
      end
      check("contention_grants", n, 4);
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_idle();

      // Consumer stalls five cycles in DONE.
      bus.out_ready = 1'b0;
      send(1'b0, 8'h81, w);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.out_valid && n < 20);
      check("stall_valid_seen", {31'd0, bus.out_valid}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      wait_idle();

      // Reset during SHIFT at counter 4 abandons the byte.
      send(1'b0, 8'hA5, w);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(1'b0, 8'h02, w);
      check("accept_after_midreset", w, 1);
      wait_idle();

      // Back-to-back from requester 1 only: accepts spaced 10 edges apart.
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'($urandom);
      prev = 0;
      n = 0;
      for (int k = 0; k < 80 && n < 5; k++) begin
         @(negedge clk);
         if (bus.req1_valid && bus.req1_ready) begin
            if (n > 0) check("b2b_spacing", cyc + 1 - prev, 10);
            prev = cyc + 1;
            n++;
            @(posedge clk);
            #1;
            bus.req1_data = 8'($urandom);
         end
      end
      check("b2b_count", n, 5);
      bus.req1_valid = 1'b0;
      wait_idle();

      // Random traffic with occasional resets.
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk);
         #1;
         bus.req0_valid = 1'($urandom_range(0, 1));
         bus.req0_data  = 8'($urandom);
         bus.req1_valid = 1'($urandom_range(0, 1));
         bus.req1_data  = 8'($urandom);
         bus.out_ready  = ($urandom_range(0, 3) != 0);
         rst_n          = ($urandom_range(0, 149) != 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.out_ready  = 1'b1;
      wait_idle();
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
